// File: rtl/sm_run_ctrl_pkg.sv
// rtl/sm_run_ctrl_pkg.sv - debug command opcodes shared with the debug-command encoder
package sm_run_ctrl_pkg;

    localparam logic [1:0] SM_RUN_OP_HALT  = 2'b00;
    localparam logic [1:0] SM_RUN_OP_RUN   = 2'b01;
    localparam logic [1:0] SM_RUN_OP_STEP  = 2'b10;
    localparam logic [1:0] SM_RUN_OP_RUNBP = 2'b11;

endpackage

// File: rtl/sm_bp_match.sv
// rtl/sm_bp_match.sv - breakpoint comparator; the first flag lets a run step off a breakpoint it starts on
module sm_bp_match #(
    parameter int PC_W = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clear,
    input  logic            active,
    input  logic            cpuEn,
    input  logic [PC_W-1:0] pc,
    input  logic [PC_W-1:0] bpAddr,
    output logic            stop
);

    logic first;

    always_ff @(posedge clk) begin
        if (rst || clear)
            first <= 1'b0;
        else if (active && cpuEn)
            first <= 1'b1;
    end

    assign stop = first && (pc == bpAddr);

endmodule

// File: rtl/sm_register_we.sv
// rtl/sm_register_we.sv - register with write enable and synchronous active-high reset
module sm_register_we #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst)
            q <= '0;
        else
            q <= we ? d : q;
    end

endmodule

// File: rtl/sm_run_ctrl.sv
// rtl/sm_run_ctrl.sv - run/halt/step controller producing cpuEn; breakpoint run built under SM_RUN_CTRL_BP_EN
module sm_run_ctrl
    import sm_run_ctrl_pkg::*;
#(
    parameter int CNT_W = 16,
    parameter int PC_W  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmdValid,
    output logic             cmdReady,
    input  logic [1:0]       cmdOp,
    input  logic [CNT_W-1:0] cmdArg,
    input  logic             haltReq,
    input  logic [PC_W-1:0]  pc,
    input  logic [PC_W-1:0]  bpAddr,
    output logic             cpuEn,
    output logic             halted,
    output logic             done,
    output logic [31:0]      cycleCnt
);

    typedef enum logic [1:0] {
        ST_HALT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_STEP  = 2'd2,
        ST_BPRUN = 2'd3
    } state_t;

    state_t           state, stateNext;
    logic [CNT_W-1:0] stepCnt, stepNext;
    logic             doneReg, doneNext;
    logic             accept;
    logic             bpStop;

`ifdef SM_RUN_CTRL_BP_EN
    sm_bp_match #(.PC_W(PC_W)) bpMatch (
        .clk    (clk),
        .rst    (rst),
        .clear  (accept && (cmdOp == SM_RUN_OP_RUNBP)),
        .active (state == ST_BPRUN),
        .cpuEn  (cpuEn),
        .pc     (pc),
        .bpAddr (bpAddr),
        .stop   (bpStop)
    );
`else
    logic unusedBp;
    assign unusedBp = ^{pc, bpAddr};
    assign bpStop   = 1'b0;
`endif

    assign cmdReady = (state != ST_STEP);
    assign halted   = (state == ST_HALT);
    assign done     = doneReg;
    assign cpuEn    = (state == ST_RUN) || (state == ST_STEP) || ((state == ST_BPRUN) && !bpStop);
    assign accept   = cmdValid && cmdReady && !haltReq;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_HALT;
            stepCnt <= '0;
            doneReg <= 1'b0;
        end else begin
            state   <= stateNext;
            stepCnt <= stepNext;
            doneReg <= doneNext;
        end
    end

    always_comb begin
        stateNext = state;
        stepNext  = stepCnt;
        doneNext  = 1'b0;

        case (state)
            ST_STEP: begin
                stepNext = stepCnt - CNT_W'(1);
                if (stepCnt == CNT_W'(1)) begin
                    stateNext = ST_HALT;
                    doneNext  = 1'b1;
                end
            end
            ST_BPRUN: begin
                if (bpStop) begin
                    stateNext = ST_HALT;
                    doneNext  = 1'b1;
                end
            end
            default: ;
        endcase

        // A new command replaces the current mode; a breakpoint hit in the same cycle still reports done.
        if (accept) begin
            case (cmdOp)
                SM_RUN_OP_HALT: stateNext = ST_HALT;
                SM_RUN_OP_RUN:  stateNext = ST_RUN;
                SM_RUN_OP_STEP: begin
                    stepNext = cmdArg;
                    if (cmdArg == '0) begin
                        stateNext = ST_HALT;
                        doneNext  = 1'b1;
                    end else begin
                        stateNext = ST_STEP;
                    end
                end
                default: begin
`ifdef SM_RUN_CTRL_BP_EN
                    stateNext = ST_BPRUN;
`else
                    stateNext = ST_RUN;
`endif
                end
            endcase
        end

        if (haltReq) begin
            stateNext = ST_HALT;
            stepNext  = '0;
            doneNext  = 1'b0;
        end
    end

    sm_register_we #(.WIDTH(32)) cycleReg (
        .clk (clk),
        .rst (rst),
        .we  (cpuEn),
        .d   (cycleCnt + 32'd1),
        .q   (cycleCnt)
    );

endmodule

// File: tb/tb_sm_run_ctrl.sv
// tb/tb_sm_run_ctrl.sv - scoreboard bench for sm_run_ctrl against a mode-level reference model
module tb_sm_run_ctrl;
    import sm_run_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmdValid = 1'b0;
    logic        cmdReady;
    logic [1:0]  cmdOp = 2'b00;
    logic [15:0] cmdArg = 16'd0;
    logic        haltReq = 1'b0;
    logic [31:0] pc = 32'd0;
    logic [31:0] bpAddr = 32'd0;
    logic        cpuEn;
    logic        halted;
    logic        done;
    logic [31:0] cycleCnt;

    always #5 clk = ~clk;

    sm_run_ctrl #(.CNT_W(16), .PC_W(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .cmdValid (cmdValid),
        .cmdReady (cmdReady),
        .cmdOp    (cmdOp),
        .cmdArg   (cmdArg),
        .haltReq  (haltReq),
        .pc       (pc),
        .bpAddr   (bpAddr),
        .cpuEn    (cpuEn),
        .halted   (halted),
        .done     (done),
        .cycleCnt (cycleCnt)
    );

    typedef struct packed {
        logic        en;
        logic        halted;
        logic        ready;
        logic        done;
        logic [31:0] cnt;
    } exp_t;

    exp_t expQ[$];
    int   checks = 0;
    int   errors = 0;

    localparam int M_HALT = 0, M_RUN = 1, M_STEP = 2, M_BP = 3;
    int          mMode  = M_HALT;
    int          mRem   = 0;
    bit          mFirst = 1'b0;
    bit          mDone  = 1'b0;
    logic [31:0] mCnt   = 32'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                chk("cpuEn",    32'(cpuEn),    32'(e.en));
                chk("halted",   32'(halted),   32'(e.halted));
                chk("cmdReady", 32'(cmdReady), 32'(e.ready));
                chk("done",     32'(done),     32'(e.done));
                chk("cycleCnt", cycleCnt,      e.cnt);
            end
        end
    end

    task automatic cyc(input bit r, input bit hr, input bit v, input logic [1:0] op,
                       input int arg, input logic [31:0] p, input logic [31:0] bp);
        exp_t e;
        bit   stop, en, acc, nd;
        @(posedge clk); #1;
        rst = r; haltReq = hr; cmdValid = v; cmdOp = op; cmdArg = 16'(arg); pc = p; bpAddr = bp;
`ifdef SM_RUN_CTRL_BP_EN
        stop = (mMode == M_BP) && mFirst && (p == bp);
`else
        stop = 1'b0;
`endif
        en = (mMode != M_HALT) && !stop;
        e.en = en; e.halted = (mMode == M_HALT); e.ready = (mMode != M_STEP);
        e.done = mDone; e.cnt = mCnt;
        expQ.push_back(e);
        acc = v && (mMode != M_STEP) && !hr;
        if (r) begin
            mMode = M_HALT; mRem = 0; mFirst = 0; mDone = 0; mCnt = 0;
        end else begin
            nd = 0;
            if (en) mCnt = mCnt + 32'd1;
            if (mMode == M_BP && en) mFirst = 1;
            if (mMode == M_STEP) begin
                mRem = mRem - 1;
                if (mRem == 0) begin mMode = M_HALT; nd = 1; end
            end
            if (stop) begin mMode = M_HALT; nd = 1; end
            if (acc) begin
                if (op == SM_RUN_OP_HALT) mMode = M_HALT;
                else if (op == SM_RUN_OP_RUN) mMode = M_RUN;
                else if (op == SM_RUN_OP_STEP) begin
                    if (arg == 0) begin mMode = M_HALT; nd = 1; end
                    else begin mMode = M_STEP; mRem = arg; end
                end else begin
`ifdef SM_RUN_CTRL_BP_EN
                    mMode = M_BP; mFirst = 0;
`else
                    mMode = M_RUN;
`endif
                end
            end
            if (hr) begin mMode = M_HALT; mRem = 0; nd = 0; end
            mDone = nd;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, SM_RUN_OP_HALT, 0, 32'd0, 32'd0);
    endtask

    // Controller must be halted; the forced value is captured by the hold path of the counter.
    task automatic preload(input logic [31:0] val);
        @(posedge clk); #1;
        rst = 0; haltReq = 0; cmdValid = 0;
        force dut.cycleReg.q = val;
        @(posedge clk); #1;
        release dut.cycleReg.q;
        mCnt = val; mDone = 0;
    endtask

    initial begin : stimulus
        logic [31:0] pcSet [4];
        pcSet[0] = 32'h0; pcSet[1] = 32'h4; pcSet[2] = 32'h8; pcSet[3] = 32'hc;
        @(posedge clk); #1;
        rst = 0;

        idle(5);

        cyc(0, 0, 1, SM_RUN_OP_STEP, 3, 32'd0, 32'd0);
        idle(6);

        for (int i = 0; i < 24; i++)
            cyc(0, 0, (i == 0), SM_RUN_OP_RUNBP, 0, 32'h10 + 32'(4 * (i % 8)), 32'h10);
        cyc(0, 0, 1, SM_RUN_OP_HALT, 0, 32'd0, 32'd0);
        idle(2);

        cyc(0, 0, 1, SM_RUN_OP_RUN, 0, 32'd0, 32'd0);
        idle(3);
        cyc(0, 1, 1, SM_RUN_OP_RUN, 0, 32'd0, 32'd0);
        idle(3);

        cyc(0, 0, 1, SM_RUN_OP_STEP, 5, 32'd0, 32'd0);
        idle(2);
        cyc(1, 0, 0, SM_RUN_OP_HALT, 0, 32'd0, 32'd0);
        idle(3);

        preload(32'hFFFF_FFFC);
        cyc(0, 0, 1, SM_RUN_OP_RUN, 0, 32'd0, 32'd0);
        idle(6);
        cyc(0, 0, 1, SM_RUN_OP_HALT, 0, 32'd0, 32'd0);
        idle(2);

        for (int i = 0; i < 3000; i++)
            cyc(($urandom % 60) == 0, ($urandom % 15) == 0, ($urandom % 3) == 0,
                2'($urandom), int'($urandom % 7), pcSet[$urandom % 4], 32'h8);
        idle(2);

        @(negedge clk); #1;
        chk("queueDrained", 32'(expQ.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
